wb_arbiter: RTL and testbench

- Writer-side counterpart of the register file's rd write port; sole driver of register writes.
- Merges two result sources:
  - ALU results: single-cycle, cannot stall.
  - LSU load results: valid/ready handshake.
- Produces one registered write per cycle. Buffers LSU results in a small FIFO.
- Exports a pending-write bitmap so issue logic can detect RAW/WAW hazards on buffered loads.

---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_arbiter_fifo.sv | 79 +++++++
 rtl/wb_arbiter.sv | 88 ++++++++
 tb/tb_wb_arbiter.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// Shared widths and the write-request record used by the write-back arbiter
// and its LSU result buffer.
package pkg_parameters;

    localparam int XLEN       = 32;
    localparam int NUM_REG    = 32;
    localparam int REG_ADDR_W = $clog2(NUM_REG);

    typedef struct packed {
        logic [REG_ADDR_W-1:0] addr;
        logic [XLEN-1:0]       data;
    } wb_req_t;

    function automatic logic [NUM_REG-1:0] reg_decode(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REG-1:0] onehot;
        onehot       = '0;
        onehot[addr] = 1'b1;
        return onehot;
    endfunction

endpackage

// File: rtl/wb_arbiter_fifo.sv
// LSU result buffer: in-order FIFO of write requests, each with a live bit
// that a younger ALU write to the same register can clear (WAW squash).
module wb_fifo
    import pkg_parameters::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  push,
    input  wb_req_t                               push_req,
    input  logic                                  pop,
    input  logic                                  squash,
    input  logic [REG_ADDR_W-1:0]                 squash_addr,
    output wb_req_t                               head,
    output logic                                  head_live,
    output logic                                  full,
    output logic                                  empty,
    output logic [DEPTH-1:0][REG_ADDR_W-1:0]      entry_addr,
    output logic [DEPTH-1:0]                      entry_live
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t          mem [DEPTH];
    logic [DEPTH-1:0] live;
    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [PW-1:0]    wr_idx;
    logic [PW-1:0]    rd_idx;
    logic             do_push;
    logic             do_pop;

    assign wr_idx  = wr_ptr[PW-1:0];
    assign rd_idx  = rd_ptr[PW-1:0];
    assign full    = (wr_ptr[PW] != rd_ptr[PW]) && (wr_idx == rd_idx);
    assign empty   = (wr_ptr == rd_ptr);
    assign do_push = push && !full && !flush;
    assign do_pop  = pop && !empty && !flush;

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Live is cleared on pop so that live alone means "occupied and will write".
    // The push update comes last: a same-cycle push is younger than the squashing ALU write.
    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            live <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && (mem[i].addr == squash_addr)) live[i] <= 1'b0;
            end
            if (do_pop)  live[rd_idx] <= 1'b0;
            if (do_push) live[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_idx] <= push_req;
    end

    assign head       = mem[rd_idx];
    assign head_live  = live[rd_idx];
    assign entry_live = live;

    always_comb begin
        entry_addr = '0;
        for (int i = 0; i < DEPTH; i++) entry_addr[i] = mem[i].addr;
    end

endmodule

// File: rtl/wb_arbiter.sv
// Register-file write-back arbiter: ALU results win every cycle, buffered LSU
// loads drain when the ALU is idle, and a pending bitmap exposes buffered loads.
module wb_arbiter #(
    parameter int XLEN      = pkg_parameters::XLEN,
    parameter int NUM_REG   = pkg_parameters::NUM_REG,
    parameter int LSU_DEPTH = 4
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic                                  flush,
    input  logic                                  alu_valid,
    input  logic [pkg_parameters::REG_ADDR_W-1:0] alu_addr,
    input  logic [XLEN-1:0]                       alu_data,
    input  logic                                  lsu_valid,
    output logic                                  lsu_ready,
    input  logic [pkg_parameters::REG_ADDR_W-1:0] lsu_addr,
    input  logic [XLEN-1:0]                       lsu_data,
    output logic                                  rd_web,
    output logic [pkg_parameters::REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]                       rd_data,
    output logic [NUM_REG-1:0]                    pending
);

    import pkg_parameters::*;

    wb_req_t                                 push_req;
    wb_req_t                                 head;
    logic                                    head_live;
    logic                                    full;
    logic                                    empty;
    logic [LSU_DEPTH-1:0][REG_ADDR_W-1:0]    entry_addr;
    logic [LSU_DEPTH-1:0]                    entry_live;
    logic                                    lsu_fire;
    logic                                    alu_squash;
    logic                                    pop;

    assign lsu_ready  = !full && rst;
    assign lsu_fire   = lsu_valid && lsu_ready;
    assign alu_squash = alu_valid && (alu_addr != '0);
    // A flush cycle never drains the buffer, so no discarded load reaches rd.
    assign pop        = !alu_valid && !flush && !empty;
    assign push_req   = '{addr: lsu_addr, data: lsu_data};

    wb_fifo #(
        .DEPTH (LSU_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush       (flush),
        .push        (lsu_fire),
        .push_req    (push_req),
        .pop         (pop),
        .squash      (alu_squash),
        .squash_addr (alu_addr),
        .head        (head),
        .head_live   (head_live),
        .full        (full),
        .empty       (empty),
        .entry_addr  (entry_addr),
        .entry_live  (entry_live)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_web  <= 1'b0;
            rd_addr <= '0;
            rd_data <= '0;
        end else if (alu_valid) begin
            rd_web  <= (alu_addr != '0);
            rd_addr <= alu_addr;
            rd_data <= alu_data;
        end else if (pop) begin
            rd_web  <= head_live && (head.addr != '0);
            rd_addr <= head.addr;
            rd_data <= head.data;
        end else begin
            rd_web  <= 1'b0;
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < LSU_DEPTH; i++) begin
            if (entry_live[i] && (entry_addr[i] != '0)) pending = pending | reg_decode(entry_addr[i]);
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: queue-based reference model checked every
// cycle, plus hand-computed literal expectations along the test plan.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        alu_valid = 1'b0;
    logic [4:0]  alu_addr = '0;
    logic [31:0] alu_data = '0;
    logic        lsu_valid = 1'b0;
    logic        lsu_ready;
    logic [4:0]  lsu_addr = '0;
    logic [31:0] lsu_data = '0;
    logic        rd_web;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] pending;

    int n_cmp = 0;
    int n_bad = 0;

    wb_arbiter #(.XLEN(32), .NUM_REG(32), .LSU_DEPTH(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_addr  (lsu_addr),
        .lsu_data  (lsu_data),
        .rd_web    (rd_web),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .pending   (pending)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h at %0t", name, got, exp, $time);
        end
    endtask

    // Reference model: list of buffered loads in arrival order.
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
        bit          live;
    } ent_t;

    ent_t        q[$];
    logic        e_web = 1'b0;
    logic [4:0]  e_addr = '0;
    logic [31:0] e_data = '0;
    bit          model_ok = 0;

    always @(posedge clk) begin
        bit   push;
        ent_t h;
        model_ok = 1;
        if (!rst) begin
            q.delete();
            e_web = 0; e_addr = '0; e_data = '0;
        end else begin
            push = lsu_valid && (q.size() < 4) && !flush;
            if (alu_valid && alu_addr != 0)
                foreach (q[i]) if (q[i].addr == alu_addr) q[i].live = 0;
            if (alu_valid) begin
                e_web = (alu_addr != 0); e_addr = alu_addr; e_data = alu_data;
            end else if (!flush && q.size() > 0) begin
                h = q.pop_front();
                e_web = h.live && (h.addr != 0); e_addr = h.addr; e_data = h.data;
            end else begin
                e_web = 0;
            end
            if (flush) q.delete();
            if (push) q.push_back('{addr: lsu_addr, data: lsu_data, live: 1'b1});
        end
    end

    always @(negedge clk) begin
        logic [31:0] e_pend;
        if (model_ok) begin
            e_pend = '0;
            foreach (q[i]) if (q[i].live && q[i].addr != 0) e_pend[q[i].addr] = 1'b1;
            check("m_rd_web", rd_web, e_web);
            check("m_rd_addr", rd_addr, e_addr);
            check("m_rd_data", rd_data, e_data);
            check("m_pending", pending, e_pend);
            check("m_lsu_ready", lsu_ready, rst && (q.size() < 4));
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] a, input logic [31:0] d);
        alu_valid = v; alu_addr = a; alu_data = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
        lsu_valid = v; lsu_addr = a; lsu_data = d;
    endtask

    initial begin
        // reset held with ALU traffic
        alu(1, 5, 32'd123);
        repeat (3) begin
            tick();
            check("rst_web", rd_web, 0);
            check("rst_pending", pending, 0);
            check("rst_ready", lsu_ready, 0);
        end
        rst = 1'b1;
        alu(0, 0, 0);
        #1 check("rel_ready", lsu_ready, 1);
        tick();

        // ALU only
        alu(1, 5, 32'hDEADBEEF);
        tick();
        check("alu_web", rd_web, 1);
        check("alu_addr", rd_addr, 5);
        check("alu_data", rd_data, 32'hDEADBEEF);
        alu(1, 0, 32'h1);
        tick();
        check("alu_x0_web", rd_web, 0);
        alu(0, 0, 0);

        // contention: buffered load waits behind three ALU writes
        lsu(1, 7, 32'h11);
        tick();
        check("cont_pend7", pending[7], 1);
        check("cont_nopass", rd_web, 0);
        lsu(0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            alu(1, 5'(i), 32'h100 + 32'(i));
            tick();
            check("cont_alu_addr", rd_addr, i);
            check("cont_pend7_hold", pending[7], 1);
        end
        alu(0, 0, 0);
        tick();
        check("cont_ld_web", rd_web, 1);
        check("cont_ld_addr", rd_addr, 7);
        check("cont_ld_data", rd_data, 32'h11);
        check("cont_pend7_clr", pending[7], 0);

        // backpressure
        alu(1, 10, 32'hA0);
        for (int i = 0; i < 4; i++) begin
            lsu(1, 5'(20 + i), 32'h200 + 32'(i));
            check("bp_ready_pre", lsu_ready, 1);
            tick();
        end
        check("bp_full", lsu_ready, 0);
        lsu(0, 0, 0);
        alu(0, 0, 0);
        tick();
        check("bp_pop0_addr", rd_addr, 20);
        check("bp_pop0_data", rd_data, 32'h200);
        check("bp_ready_back", lsu_ready, 1);
        for (int i = 1; i < 4; i++) begin
            tick();
            check("bp_pop_addr", rd_addr, 20 + i);
            check("bp_pop_web", rd_web, 1);
        end
        tick();
        check("bp_idle_web", rd_web, 0);

        // WAW squash
        lsu(1, 9, 32'hAA);
        tick();
        check("waw_pend9", pending[9], 1);
        lsu(0, 0, 0);
        alu(1, 9, 32'hBB);
        tick();
        check("waw_alu_web", rd_web, 1);
        check("waw_alu_data", rd_data, 32'hBB);
        check("waw_pend9_clr", pending[9], 0);
        alu(0, 0, 0);
        tick();
        check("waw_drain_web", rd_web, 0);
        check("waw_drain_data", rd_data, 32'hAA);
        alu(1, 9, 32'hCC);
        lsu(1, 9, 32'hDD);
        tick();
        check("waw_same_data", rd_data, 32'hCC);
        check("waw_same_pend9", pending[9], 1);
        alu(0, 0, 0);
        lsu(0, 0, 0);
        tick();
        check("waw_young_web", rd_web, 1);
        check("waw_young_data", rd_data, 32'hDD);

        // load to x0 drains silently
        lsu(1, 0, 32'h55);
        tick();
        check("x0_pending", pending, 0);
        lsu(0, 0, 0);
        tick();
        check("x0_web", rd_web, 0);
        check("x0_data", rd_data, 32'h55);

        // flush with three buffered entries
        alu(1, 1, 32'h1);
        for (int i = 0; i < 3; i++) begin
            lsu(1, 5'(11 + i), 32'h300 + 32'(i));
            tick();
        end
        check("fl_pending_pre", pending, 32'h0000_3800);
        alu(0, 0, 0);
        lsu(1, 14, 32'h14);
        flush = 1'b1;
        #1 check("fl_ready", lsu_ready, 1);
        tick();
        check("fl_pending", pending, 0);
        check("fl_web", rd_web, 0);
        flush = 1'b0;
        lsu(0, 0, 0);
        repeat (3) begin
            tick();
            check("fl_no_ld", rd_web, 0);
        end

        // ALU write completes during flush
        lsu(1, 15, 32'h15);
        tick();
        lsu(0, 0, 0);
        flush = 1'b1;
        alu(1, 4, 32'h44);
        tick();
        check("fl_alu_web", rd_web, 1);
        check("fl_alu_addr", rd_addr, 4);
        check("fl_alu_pend", pending, 0);
        flush = 1'b0;
        alu(0, 0, 0);
        tick();
        check("fl_after_web", rd_web, 0);

        repeat (2) tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
